// File: rtl/id_stage_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : id_stage_ctrl_pkg
//  Purpose : Shared opcode constants, NOP encoding, decode-stage state
//            encodings and register-usage helpers for id_stage_ctrl.
//  Revision: 1.0  initial release
// ============================================================================
package id_stage_ctrl_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ID_EMPTY    = 2'd0,
    ID_FULL     = 2'd1,
    ID_LU_STALL = 2'd2
  } id_state_e;

  // U-type and JAL carry immediate bits in the rs1 field; it must not be
  // treated as a register read.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == OPCODE_LUI) || (opcode == OPCODE_AUIPC) ||
             (opcode == OPCODE_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPCODE_R_TYPE) || (opcode == OPCODE_STORE) ||
           (opcode == OPCODE_BRANCH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_ctrl_hazard_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : hazard_detect
//  Purpose : Combinational load-use hazard check between the instruction in
//            ID (decoded fields) and a load sitting in ID/EX.
//  Ports   : opcode/rs1/rs2  decoded fields of the ID instruction
//            ex_valid        ID/EX holds a live instruction
//            ex_is_load      ID/EX instruction is a load
//            ex_rd           destination of the ID/EX instruction
//            hazard          ID instruction reads the pending load result
//  Revision: 1.0  initial release
// ============================================================================
module hazard_detect
  import id_stage_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  always_comb begin
    // x0 is hardwired zero, so a load to it never produces a dependency.
    hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
             ((uses_rs1(opcode) && (rs1 == ex_rd)) ||
              (uses_rs2(opcode) && (rs2 == ex_rd)));
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : id_stage_ctrl
//  Purpose : Decode-stage sequencer. Owns the IF/ID and ID/EX registers,
//            feeds the external decoder, inserts one bubble per load-use
//            pair and flushes younger work on an EX redirect.
//  Ports   : if_valid/if_instr/if_pc    fetch side, accepted when id_ready
//            id_ready                   ID can accept (no path from if_valid)
//            id_instr                   IF/ID instruction to the decoder
//            dec_opcode/rs1/rs2/rd      decoder fields of id_instr
//            ex_valid/ex_instr/ex_pc    ID/EX contents, consumed on ex_ready
//            redirect                   taken branch/jump in EX, flush
//            stall_count/flush_count    saturating event counters
//  Revision: 1.0  initial release
// ============================================================================
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  output logic [XLEN-1:0]  id_instr,
  input  logic [6:0]       dec_opcode,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_instr,
  output logic [XLEN-1:0]  ex_pc,
  input  logic             ex_ready,
  input  logic             redirect,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  id_state_e        state_q, state_d;
  logic [XLEN-1:0]  id_instr_q, id_instr_d;
  logic [XLEN-1:0]  id_pc_q, id_pc_d;
  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_instr_q, ex_instr_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_is_load_q, ex_is_load_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic id_valid;
  logic ex_hazard;
  logic hazard;
  logic ex_free;
  logic advance;
  logic accept;

  hazard_detect u_hazard_detect (
    .opcode     (dec_opcode),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .ex_valid   (ex_valid_q),
    .ex_is_load (ex_is_load_q),
    .ex_rd      (ex_rd_q),
    .hazard     (ex_hazard)
  );

  always_comb begin
    id_valid = (state_q != ID_EMPTY);
    hazard   = id_valid && ex_hazard;
    ex_free  = !ex_valid_q || ex_ready;
    advance  = id_valid && ex_free && !hazard;
    // Depends only on state, ex_ready, decode fields and redirect.
    id_ready = !redirect && (!id_valid || advance);
    accept   = if_valid && id_ready;

    state_d       = state_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    ex_valid_d    = ex_valid_q;
    ex_instr_d    = ex_instr_q;
    ex_pc_d       = ex_pc_q;
    ex_rd_d       = ex_rd_q;
    ex_is_load_d  = ex_is_load_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    if (redirect) begin
      // Everything younger than the resolving branch is discarded; a pending
      // bubble is irrelevant once ID is emptied.
      state_d    = ID_EMPTY;
      ex_valid_d = 1'b0;
      if (flush_count_q != {CNT_W{1'b1}}) begin
        flush_count_d = flush_count_q + CNT_W'(1);
      end
    end else begin
      if (accept) begin
        id_instr_d = if_instr;
        id_pc_d    = if_pc;
      end

      unique case (state_q)
        ID_EMPTY: begin
          if (accept) state_d = ID_FULL;
        end
        ID_FULL, ID_LU_STALL: begin
          // In LU_STALL EX holds the bubble, so advance is always true and
          // the same load can never trigger a second bubble.
          if (advance) begin
            state_d = accept ? ID_FULL : ID_EMPTY;
          end else if (hazard && ex_ready) begin
            state_d = ID_LU_STALL;
            if (stall_count_q != {CNT_W{1'b1}}) begin
              stall_count_d = stall_count_q + CNT_W'(1);
            end
          end else begin
            state_d = ID_FULL;
          end
        end
        default: state_d = ID_EMPTY;
      endcase

      if (advance) begin
        ex_valid_d   = 1'b1;
        ex_instr_d   = id_instr_q;
        ex_pc_d      = id_pc_q;
        ex_rd_d      = dec_rd;
        ex_is_load_d = (dec_opcode == OPCODE_LOAD);
      end else if (ex_ready) begin
        ex_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ID_EMPTY;
      id_instr_q    <= XLEN'(NOP_INSTR);
      id_pc_q       <= '0;
      ex_valid_q    <= 1'b0;
      ex_instr_q    <= XLEN'(NOP_INSTR);
      ex_pc_q       <= '0;
      ex_rd_q       <= 5'd0;
      ex_is_load_q  <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      ex_valid_q    <= ex_valid_d;
      ex_instr_q    <= ex_instr_d;
      ex_pc_q       <= ex_pc_d;
      ex_rd_q       <= ex_rd_d;
      ex_is_load_q  <= ex_is_load_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign id_instr    = id_instr_q;
  assign ex_valid    = ex_valid_q;
  assign ex_instr    = ex_instr_q;
  assign ex_pc       = ex_pc_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
`default_nettype wire
